// File: rtl/control_seq_pkg.sv
// Shared opcode, sub-op and branch-condition codes plus the sequencer state
// encoding for the control sequencer.
package ctrl_pkg;
  localparam logic [2:0] ALU_MEM = 3'b010;
  localparam logic [2:0] SET     = 3'b011;
  localparam logic [2:0] MOVI    = 3'b100;
  localparam logic [2:0] MOVO    = 3'b101;
  localparam logic [2:0] BR      = 3'b110;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_INPL  = 2'b01;
  localparam logic [1:0] MEM_LOAD  = 2'b10;
  localparam logic [1:0] MEM_STORE = 2'b11;

  localparam logic [1:0] BC_NE = 2'b00;
  localparam logic [1:0] BC_EQ = 2'b01;
  localparam logic [1:0] BC_GT = 2'b10;
  localparam logic [1:0] BC_LT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, LOAD_WAIT, HALTED} state_t;
endpackage

// File: rtl/control_seq_if.sv
// Instruction/flag inputs and datapath control outputs of the sequencer.
interface control_seq_if #(
  parameter int IW  = 9,
  parameter int RSW = 4,
  parameter int TW  = 6
);
  logic          Start;
  logic [IW-1:0] Instruction;
  logic          InstrValid;
  logic          Eq, Gt, Lt, FlagWe;
  logic          BranchEn, MemRead, MemWrite, Imm, RegWrite, Inplace, Move;
  logic [RSW-1:0] RegSel;
  logic [3:0]    MoveFrom;
  logic [TW-1:0] TargSel;
  logic          PcEn, Stall, Done;

  modport master (
    output Start, Instruction, InstrValid, Eq, Gt, Lt, FlagWe,
    input  BranchEn, MemRead, MemWrite, Imm, RegWrite, Inplace, Move,
           RegSel, MoveFrom, TargSel, PcEn, Stall, Done
  );
  modport slave (
    input  Start, Instruction, InstrValid, Eq, Gt, Lt, FlagWe,
    output BranchEn, MemRead, MemWrite, Imm, RegWrite, Inplace, Move,
           RegSel, MoveFrom, TargSel, PcEn, Stall, Done
  );
endinterface

// File: rtl/control_seq_decode.sv
// Pure combinational decode of one instruction word against the latched flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IW  = 9,
  parameter int RSW = 4,
  parameter int TW  = 6
) (
  input  logic [IW-1:0]  instr,
  input  logic           eqr, gtr, ltr,
  output logic           branch_en, mem_read, mem_write, imm, reg_write, inplace, move,
  output logic [RSW-1:0] reg_sel,
  output logic [3:0]     move_from,
  output logic [TW-1:0]  targ_sel,
  output logic           pc_en, is_load, is_halt
);
  logic [2:0] op;
  logic [1:0] sub;
  logic       take;

  assign op  = instr[IW-1:IW-3];
  assign sub = instr[5:4];

  always_comb begin
    case (sub)
      BC_NE:   take = !eqr;
      BC_EQ:   take = eqr;
      BC_GT:   take = gtr;
      default: take = ltr;
    endcase
  end

  always_comb begin
    branch_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0; imm = 1'b0;
    reg_write = 1'b1; inplace = 1'b0; move = 1'b0;
    reg_sel   = instr[RSW-1:0];
    move_from = '0;
    targ_sel  = '0;
    pc_en     = 1'b1;
    is_load   = 1'b0;
    is_halt   = 1'b0;
    // all-ones word is halt and overrides opcode 111 decoding
    if (&instr) begin
      reg_write = 1'b0; reg_sel = '0; pc_en = 1'b0; is_halt = 1'b1;
    end else begin
      case (op)
        ALU_MEM: case (sub)
          MEM_LOAD:  begin mem_read = 1'b1; is_load = 1'b1; end
          MEM_STORE: begin mem_write = 1'b1; reg_write = 1'b0; end
          MEM_INPL:  inplace = 1'b1;
          default:   ;
        endcase
        SET: begin imm = 1'b1; reg_sel = '0; end
        MOVI: begin
          move = 1'b1; reg_sel = {{(RSW-1){1'b0}}, instr[1]}; move_from = instr[5:2];
        end
        MOVO: begin move = 1'b1; move_from = {3'b000, instr[5]}; end
        BR: begin
          reg_write = 1'b0;
          if (take) begin branch_en = 1'b1; targ_sel = instr[TW-1:0]; end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/control_seq.sv
// Control sequencer: run/halt FSM, multi-cycle load wait, compare-flag
// registers and destination capture around the ctrl_decode block.
module control_seq
  import ctrl_pkg::*;
#(
  parameter int IW       = 9,
  parameter int RSW      = 4,
  parameter int TW       = 6,
  parameter int LOAD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  control_seq_if.slave bus
);
  state_t         state, nxt;
  logic [2:0]     cnt;
  logic           eqr, gtr, ltr, done, ld_go;
  logic [RSW-1:0] cap_rs;

  logic           d_br, d_mr, d_mw, d_imm, d_rw, d_inp, d_mv, d_pc, d_load, d_halt;
  logic [RSW-1:0] d_rs;
  logic [3:0]     d_mf;
  logic [TW-1:0]  d_ts;

  ctrl_decode #(.IW(IW), .RSW(RSW), .TW(TW)) u_dec (
    .instr(bus.Instruction), .eqr(eqr), .gtr(gtr), .ltr(ltr),
    .branch_en(d_br), .mem_read(d_mr), .mem_write(d_mw), .imm(d_imm),
    .reg_write(d_rw), .inplace(d_inp), .move(d_mv), .reg_sel(d_rs),
    .move_from(d_mf), .targ_sel(d_ts), .pc_en(d_pc), .is_load(d_load),
    .is_halt(d_halt)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      eqr    <= 1'b0; gtr <= 1'b0; ltr <= 1'b0;
      cap_rs <= '0;
      done   <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (nxt == HALTED);
      if (bus.FlagWe) begin
        eqr <= bus.Eq; gtr <= bus.Gt; ltr <= bus.Lt;
      end
      if (ld_go) begin
        cnt    <= 3'(LOAD_LAT);
        cap_rs <= d_rs;
      end else if (state == LOAD_WAIT) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_comb begin
    nxt          = state;
    ld_go        = 1'b0;
    bus.BranchEn = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Imm = 1'b0;
    bus.RegWrite = 1'b0; bus.Inplace = 1'b0; bus.Move = 1'b0;
    bus.RegSel   = '0;   bus.MoveFrom = '0;  bus.TargSel = '0;
    bus.PcEn     = 1'b0; bus.Stall = 1'b0;
    case (state)
      IDLE, HALTED: if (bus.Start) nxt = RUN;
      RUN: if (bus.InstrValid) begin
        bus.BranchEn = d_br;  bus.MemRead = d_mr; bus.MemWrite = d_mw; bus.Imm = d_imm;
        bus.RegWrite = d_rw;  bus.Inplace = d_inp; bus.Move = d_mv;
        bus.RegSel   = d_rs;  bus.MoveFrom = d_mf; bus.TargSel = d_ts;
        bus.PcEn     = d_pc;
        if (d_halt) begin
          nxt = HALTED;
        end else if (d_load && (LOAD_LAT > 0)) begin
          // first load cycle only issues the read; writeback waits for data
          bus.RegWrite = 1'b0; bus.PcEn = 1'b0; bus.Stall = 1'b1;
          ld_go = 1'b1;
          nxt   = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        bus.MemRead = 1'b1;
        bus.RegSel  = cap_rs;
        if (cnt == 3'd1) begin
          bus.RegWrite = 1'b1; bus.PcEn = 1'b1; nxt = RUN;
        end else begin
          bus.Stall = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.Done = done;
endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: vector table plus load/halt/reset sequences.
module tb_control_seq;
  typedef struct packed {
    logic [6:0] b;   // BranchEn MemRead MemWrite Imm RegWrite Inplace Move
    logic [3:0] rs;
    logic [3:0] mf;
    logic [5:0] ts;
    logic [2:0] t;   // PcEn Stall Done
  } out_t;

  typedef struct {
    string      nm;
    logic [8:0] ins;
    logic       v, st, fwe, eq, gt, lt;
    out_t       e;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_fail = 0;
  out_t sb_q[$];
  vec_t tbl[19];

  control_seq_if #(.IW(9), .RSW(4), .TW(6)) bus ();
  control_seq #(.IW(9), .RSW(4), .TW(6), .LOAD_LAT(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  function automatic out_t o(input logic [6:0] b, input logic [3:0] rs, mf,
                             input logic [5:0] ts, input logic [2:0] t);
    return '{b: b, rs: rs, mf: mf, ts: ts, t: t};
  endfunction

  function automatic out_t got_out();
    return '{b:  {bus.BranchEn, bus.MemRead, bus.MemWrite, bus.Imm, bus.RegWrite,
                  bus.Inplace, bus.Move},
             rs: bus.RegSel, mf: bus.MoveFrom, ts: bus.TargSel,
             t:  {bus.PcEn, bus.Stall, bus.Done}};
  endfunction

  task automatic drive(input logic [8:0] ins, input logic v, st, fwe, eq, gt, lt);
    bus.Instruction = ins; bus.InstrValid = v; bus.Start = st;
    bus.FlagWe = fwe; bus.Eq = eq; bus.Gt = gt; bus.Lt = lt;
  endtask

  task automatic check(input string nm);
    out_t e, g;
    e = sb_q.pop_front();
    g = got_out();
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got b=%b rs=%h mf=%h ts=%h pc/st/dn=%b, expected b=%b rs=%h mf=%h ts=%h pc/st/dn=%b",
               nm, g.b, g.rs, g.mf, g.ts, g.t, e.b, e.rs, e.mf, e.ts, e.t);
    end
  endtask

  task automatic step(input string nm, input logic [8:0] ins, input logic v, st, fwe,
                      eq, gt, lt, input out_t e);
    @(negedge Clk);
    drive(ins, v, st, fwe, eq, gt, lt);
    sb_q.push_back(e);
    #2;
    check(nm);
  endtask

  initial begin
    out_t z, set_o, ld0, ld2;
    z     = o(7'b0000000, 4'h0, 4'h0, 6'h00, 3'b000);
    set_o = o(7'b0001100, 4'h0, 4'h0, 6'h00, 3'b100);
    ld0   = o(7'b0100000, 4'h5, 4'h0, 6'h00, 3'b010);
    ld2   = o(7'b0100100, 4'h5, 4'h0, 6'h00, 3'b100);

    tbl[0]  = '{"set",         9'h0C7, 1, 0, 0, 0, 0, 0, set_o};
    tbl[1]  = '{"store",       9'h0B3, 1, 0, 0, 0, 0, 0, o(7'b0010000, 4'h3, 4'h0, 6'h00, 3'b100)};
    tbl[2]  = '{"inplace",     9'h095, 1, 0, 0, 0, 0, 0, o(7'b0000110, 4'h5, 4'h0, 6'h00, 3'b100)};
    tbl[3]  = '{"mem_nop",     9'h08A, 1, 0, 0, 0, 0, 0, o(7'b0000100, 4'hA, 4'h0, 6'h00, 3'b100)};
    tbl[4]  = '{"movi",        9'h12D, 1, 0, 0, 0, 0, 0, o(7'b0000101, 4'h0, 4'hB, 6'h00, 3'b100)};
    tbl[5]  = '{"movo",        9'h16E, 1, 0, 0, 0, 0, 0, o(7'b0000101, 4'hE, 4'h1, 6'h00, 3'b100)};
    tbl[6]  = '{"br_old_flag", 9'h193, 1, 0, 1, 1, 0, 0, o(7'b0000000, 4'h3, 4'h0, 6'h00, 3'b100)};
    tbl[7]  = '{"br_eq_take",  9'h193, 1, 0, 0, 0, 0, 0, o(7'b1000000, 4'h3, 4'h0, 6'h13, 3'b100)};
    tbl[8]  = '{"br_ne_not",   9'h183, 1, 0, 1, 0, 1, 0, o(7'b0000000, 4'h3, 4'h0, 6'h00, 3'b100)};
    tbl[9]  = '{"br_ne_take",  9'h183, 1, 0, 0, 0, 0, 0, o(7'b1000000, 4'h3, 4'h0, 6'h03, 3'b100)};
    tbl[10] = '{"br_gt_take",  9'h1A7, 1, 0, 0, 0, 0, 0, o(7'b1000000, 4'h7, 4'h0, 6'h27, 3'b100)};
    tbl[11] = '{"no_valid",    9'h0C7, 0, 0, 0, 0, 0, 0, z};
    tbl[12] = '{"op000",       9'h005, 1, 0, 0, 0, 0, 0, o(7'b0000100, 4'h5, 4'h0, 6'h00, 3'b100)};
    tbl[13] = '{"op111",       9'h1C4, 1, 0, 0, 0, 0, 0, o(7'b0000100, 4'h4, 4'h0, 6'h00, 3'b100)};
    tbl[14] = '{"br_lt_not",   9'h1B8, 1, 0, 0, 0, 0, 0, o(7'b0000000, 4'h8, 4'h0, 6'h00, 3'b100)};
    tbl[15] = '{"halt",        9'h1FF, 1, 0, 0, 0, 0, 0, z};
    tbl[16] = '{"halted",      9'h0C7, 1, 0, 0, 0, 0, 0, o(7'b0000000, 4'h0, 4'h0, 6'h00, 3'b001)};
    tbl[17] = '{"halt_start",  9'h0C7, 0, 1, 0, 0, 0, 0, o(7'b0000000, 4'h0, 4'h0, 6'h00, 3'b001)};
    tbl[18] = '{"resume",      9'h0C7, 1, 0, 0, 0, 0, 0, set_o};

    Reset = 1'b1;
    drive(9'h000, 0, 0, 0, 0, 0, 0);
    step("in_reset", 9'h0A5, 1, 0, 0, 0, 0, 0, z);
    Reset = 1'b0;
    step("idle_valid", 9'h0C7, 1, 0, 0, 0, 0, 0, z);
    step("idle_start", 9'h000, 0, 1, 0, 0, 0, 0, z);

    foreach (tbl[i])
      step(tbl[i].nm, tbl[i].ins, tbl[i].v, tbl[i].st, tbl[i].fwe, tbl[i].eq,
           tbl[i].gt, tbl[i].lt, tbl[i].e);

    // two-cycle load wait; instruction inputs must be ignored while waiting
    step("ld_c0", 9'h0A5, 1, 0, 0, 0, 0, 0, ld0);
    step("ld_c1", 9'h1FF, 1, 1, 0, 0, 0, 0, ld0);
    step("ld_c2", 9'h0B3, 1, 0, 0, 0, 0, 0, ld2);
    step("ld_back_run", 9'h0C7, 1, 0, 0, 0, 0, 0, set_o);

    // asynchronous reset in the middle of a load wait
    step("ld2_c0", 9'h0A5, 1, 0, 0, 0, 0, 0, ld0);
    @(negedge Clk);
    drive(9'h0C7, 1, 0, 0, 0, 0, 0);
    sb_q.push_back(z);
    #1 Reset = 1'b1;
    #1 check("rst_mid_load");
    #1 Reset = 1'b0;
    step("post_rst_idle", 9'h0C7, 1, 0, 0, 0, 0, 0, z);
    step("post_rst_start", 9'h000, 0, 1, 0, 0, 0, 0, z);
    step("post_rst_flags", 9'h1A7, 1, 0, 0, 0, 0, 0, o(7'b0000000, 4'h7, 4'h0, 6'h00, 3'b100));
    step("post_rst_set", 9'h0C7, 1, 0, 0, 0, 0, 0, set_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
